// File: rtl/ifetch_btb_pkg.sv
// Shared definitions for the fetch stage and its direct-mapped BTB:
// default geometry, reset PC, bubble word and 2-bit counter encodings.
package ifetch_btb_pkg;

  localparam int          ROM_AW_DEF   = 10;
  localparam int          BTB_IDX_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  // Saturating step of a 2-bit direction counter.
  function automatic ctr_e ctrStep(input ctr_e cur, input logic taken);
    logic [1:0] raw;
    raw = cur;
    if (taken) begin
      if (cur != CTR_ST) raw = raw + 2'd1;
    end else begin
      if (cur != CTR_SNT) raw = raw - 2'd1;
    end
    return ctr_e'(raw);
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// synchronous training port; a same-index lookup sees pre-update contents.
module btb_dm
  import ifetch_btb_pkg::*;
#(
  parameter int BTB_IDX = BTB_IDX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_o,
  output logic [31:0] target_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_taken_i
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = 32 - BTB_IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];

  logic [BTB_IDX-1:0] lookupIdx;
  logic [BTB_IDX-1:0] updIdx;
  logic [TAG_W-1:0]   lookupTag;
  logic [TAG_W-1:0]   updTag;
  logic               lookupHit;
  logic               updHit;
  logic [3:0]         unusedLowBits;

  assign lookupIdx     = lookup_pc_i[BTB_IDX+1:2];
  assign lookupTag     = lookup_pc_i[31:BTB_IDX+2];
  assign updIdx        = upd_pc_i[BTB_IDX+1:2];
  assign updTag        = upd_pc_i[31:BTB_IDX+2];
  assign unusedLowBits = {lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lookupHit = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
  assign predict_o = lookupHit && ctr_q[lookupIdx][1];
  assign target_o  = target_q[lookupIdx];
  assign updHit    = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  // A miss that resolves taken evicts whatever alias held the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_en_i) begin
      if (updHit) begin
        ctr_q[updIdx] <= ctrStep(ctr_q[updIdx], upd_taken_i);
        if (upd_taken_i) target_q[updIdx] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= upd_target_i;
        ctr_q[updIdx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/ifetch_btb.sv
// Instruction-fetch stage: PC register, ROM addressing, IF/ID latch and
// next-PC selection between redirect, halt, stall and BTB prediction.
module ifetch_btb
  import ifetch_btb_pkg::*;
#(
  parameter int          ROM_AW   = ROM_AW_DEF,
  parameter int          BTB_IDX  = BTB_IDX_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_pred_taken,
  output logic [31:0]       if_id_pred_target
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic        predTaken_q, predTaken_d;
  logic [31:0] predTarget_q, predTarget_d;

  logic        predict;
  logic [31:0] btbTarget;
  logic [31:0] predNext;

  btb_dm #(.BTB_IDX(BTB_IDX)) uBtb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc_i  (pc_q),
    .predict_o    (predict),
    .target_o     (btbTarget),
    .upd_en_i     (upd_en),
    .upd_pc_i     (upd_pc),
    .upd_target_i (upd_target),
    .upd_taken_i  (upd_taken)
  );

  assign predNext = predict ? btbTarget : (pc_q + 32'd4);
  assign rom_addr = pc_q[ROM_AW+1:2];

  // Redirect beats halt beats stall; a bubble also clears pc/target fields.
  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifPc_d       = ifPc_q;
    predTaken_d  = predTaken_q;
    predTarget_d = predTarget_q;
    if (redirect || halt) begin
      valid_d      = 1'b0;
      instr_d      = NOP_WORD;
      ifPc_d       = '0;
      predTaken_d  = 1'b0;
      predTarget_d = '0;
      if (redirect) pc_d = redirect_pc;
    end else if (!stall) begin
      pc_d         = predNext;
      valid_d      = 1'b1;
      instr_d      = rom_data;
      ifPc_d       = pc_q;
      predTaken_d  = predict;
      predTarget_d = predNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= NOP_WORD;
      ifPc_q       <= '0;
      predTaken_q  <= 1'b0;
      predTarget_q <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifPc_q       <= ifPc_d;
      predTaken_q  <= predTaken_d;
      predTarget_q <= predTarget_d;
    end
  end

  assign if_id_valid       = valid_q;
  assign if_id_instr       = instr_q;
  assign if_id_pc          = ifPc_q;
  assign if_id_pred_taken  = predTaken_q;
  assign if_id_pred_target = predTarget_q;

endmodule

// File: doc/ifetch_btb.md
Name: ifetch_btb

Overview:
Instruction-fetch stage of the redirection pipeline with BTB. It holds the PC and drives the word address into the combinational instruction ROM, then latches the returned word into the IF/ID register. It predicts the next PC with a direct-mapped branch target buffer (BTB) using 2-bit saturating counters. The BTB is trained and corrected by EX-stage resolve/redirect inputs.

Parameters:
ROM_AW, 10, ROM word-address width; rom_addr = pc[ROM_AW+1:2]
BTB_IDX, 4, BTB index bits (16 entries); index = pc[BTB_IDX+1:2]
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ROM_AW  word address to instruction ROM
rom_data  in  32  instruction word from ROM, same cycle
stall  in  1  hazard unit: hold PC and IF/ID
halt  in  1  syscall-halt latch from ID/EX: freeze PC, insert bubbles
redirect  in  1  EX mispredict: load redirect_pc, flush IF/ID
redirect_pc  in  32  corrected PC
upd_en  in  1  EX resolved a branch/jump this cycle
upd_pc  in  32  PC of resolved instruction
upd_target  in  32  resolved target
upd_taken  in  1  resolved direction
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  latched instruction
if_id_pc  out  32  PC of latched instruction
if_id_pred_taken  out  1  BTB predicted taken for this instruction
if_id_pred_target  out  32  predicted next PC (target or pc+4)

Behaviour:
- Reset (async): pc=RESET_PC; all BTB valid=0, counters=2'b01; if_id_valid=0, instr=0, pc=0, pred_taken=0, pred_target=0.
- rom_addr = pc[ROM_AW+1:2], combinational from the PC register. The fetch latency is one cycle: the word at pc appears on if_id_instr after the next rising edge.
- BTB lookup (combinational on pc): hit = valid[idx] && tag[idx]==pc[31:BTB_IDX+2]. predict = hit && ctr[idx][1]. pred_next = predict ? target[idx] : pc+4.
- Next-PC priority, evaluated per edge:
  1. redirect: pc<=redirect_pc; IF/ID <= bubble (valid=0, instr=0, pred_taken=0).
  2. halt: pc holds; IF/ID <= bubble.
  3. stall: pc and IF/ID hold.
  4. Otherwise: pc<=pred_next; IF/ID <= {1, rom_data, pc, predict, pred_next}.
- redirect overrides stall and halt in the same cycle.
- halt is level-sensitive. Deasserting halt resumes fetch from the held pc.
- BTB update on edge when upd_en is high (independent of stall/halt/redirect):
  - Hit on upd_pc: counter increments if taken, decrements if not, saturating at 0/3. target<=upd_target if taken.
  - Miss and taken: allocate (overwrite) entry with valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- A lookup and an update at the same index in the same cycle: the lookup uses pre-update contents; the write lands at the edge.
- PC arithmetic is 32-bit modulo 2^32. pc+4 wraps 0xFFFF_FFFC to 0. Only bits [ROM_AW+1:2] reach the ROM, so the address wraps at 4 KiB.
- Reset mid-operation clears the BTB fully; there is no partial state.

Decomposition:
- Shared package: BTB_IDX/ROM_AW defaults, NOP word 32'h0, counter encodings (SNT=0, WNT=1, WT=2, ST=3), RESET_PC.
- One sub-module, btb_dm: the storage arrays, combinational lookup port and synchronous update port. The PC/IF-ID logic stays in ifetch_btb.

Test Plan:
- Reset then release with rom_data=0x20110001 at addr 0: rom_addr=0 during reset. First edge gives if_id_valid=1, instr=0x20110001, pc=0, pred_taken=0, and the next rom_addr=1.
- Cold BTB at pc=0x4 (instr 0x08000005): fetch continues to pc=0x8. Apply upd_en with upd_pc=0x4, target=0x14, taken=1. The next visit to pc=0x4 predicts taken: rom_addr goes 1→5 and if_id_pred_target=0x14.
- Counter saturation on pc=0x4: apply 3 taken updates (ctr=3), then 1 not-taken, and it still predicts taken. A second not-taken (ctr=1) gives a not-taken prediction and next pc=0x8.
- stall=1 for 3 cycles: pc and all if_id_* outputs are unchanged. Assert redirect=1 with redirect_pc=0x48 during the stall: the next edge gives pc=0x48 and if_id_valid=0.
- halt=1 after the syscall word 0x0000000C: pc freezes and if_id_valid=0 every cycle. halt=0 resumes fetch at the held pc.
- Alias eviction: allocate pc=0x4, then apply a taken update for pc=0x44 (same index, different tag). The entry is replaced, and a lookup at pc=0x4 misses (pred_taken=0).
